// File: rtl/kernel_convolver.sv
// Gaussian-kernel consumer: latches a SIZE x SIZE weight kernel, sums it, then filters
// one pixel window at a time with a MAC accumulator and a sequential restoring divider.
module kernel_convolver #(
  parameter int SIZE = 4'd7
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [SIZE-1:0][SIZE-1:0][7:0]      kernel,
  input  logic                                kernel_load,
  output logic                                kernel_ready,
  output logic [8+$clog2(SIZE*SIZE)-1:0]      ksum,
  output logic                                err,
  input  logic [7:0]                          pix_in,
  input  logic                                pix_valid,
  output logic                                pix_ready,
  output logic [7:0]                          out_pix,
  output logic                                out_valid,
  input  logic                                out_ready
);

  localparam int N     = SIZE * SIZE;
  localparam int CW    = $clog2(N);
  localparam int ACC_W = 16 + CW;
  localparam int SUM_W = 8 + CW;
  localparam int DCW   = $clog2(ACC_W);
  localparam logic [CW-1:0]  LAST_IDX = CW'(N - 1);
  localparam logic [DCW-1:0] LAST_DIV = DCW'(ACC_W - 1);

  typedef enum logic [2:0] {EMPTY, LOAD, RUN, DIV, DONE} state_t;

  state_t              state, state_n;
  logic [N-1:0][7:0]   kreg;
  logic [SUM_W-1:0]    wsum, wsum_n, rem, diff;
  logic [SUM_W:0]      trial;
  logic [ACC_W-1:0]    acc;
  logic [CW-1:0]       idx;
  logic [DCW-1:0]      divcnt;
  logic [15:0]         prod;
  logic                qbit, restart, beat, last;

  assign restart   = kernel_load && (state != LOAD);
  assign pix_ready = (state == RUN);
  assign out_valid = (state == DONE);
  assign beat      = pix_valid && pix_ready;
  assign last      = (idx == LAST_IDX);
  assign wsum_n    = wsum + {{CW{1'b0}}, kreg[idx]};
  assign prod      = {8'b0, kreg[idx]} * {8'b0, pix_in};

  // Restoring step: the remainder stays below ksum, so the SUM_W-bit difference is exact.
  assign trial = {rem, acc[ACC_W-1]};
  assign qbit  = (trial >= {1'b0, ksum});
  assign diff  = trial[SUM_W-1:0] - ksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (restart) state_n = LOAD;
    else begin
      case (state)
        EMPTY:   state_n = EMPTY;
        LOAD:    if (last) state_n = (wsum_n == '0) ? EMPTY : RUN;
        RUN:     if (beat && last) state_n = DIV;
        DIV:     if (divcnt == LAST_DIV) state_n = DONE;
        DONE:    if (out_ready) state_n = RUN;
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kreg         <= '0;
      wsum         <= '0;
      ksum         <= '0;
      err          <= 1'b0;
      kernel_ready <= 1'b0;
      acc          <= '0;
      idx          <= '0;
      rem          <= '0;
      divcnt       <= '0;
      out_pix      <= '0;
    end else if (restart) begin
      kreg         <= kernel;
      wsum         <= '0;
      err          <= 1'b0;
      kernel_ready <= 1'b0;
      acc          <= '0;
      idx          <= '0;
    end else begin
      case (state)
        LOAD: begin
          wsum <= wsum_n;
          if (last) begin
            idx <= '0;
            if (wsum_n == '0) err <= 1'b1;
            else begin
              ksum         <= wsum_n;
              kernel_ready <= 1'b1;
            end
          end else idx <= idx + 1'b1;
        end
        RUN: if (beat) begin
          acc <= acc + {{CW{1'b0}}, prod};
          if (last) begin
            idx    <= '0;
            rem    <= '0;
            divcnt <= '0;
          end else idx <= idx + 1'b1;
        end
        // The dividend shifts out of acc's top while quotient bits fill its bottom.
        DIV: begin
          rem    <= qbit ? diff : trial[SUM_W-1:0];
          acc    <= {acc[ACC_W-2:0], qbit};
          divcnt <= divcnt + 1'b1;
          if (divcnt == LAST_DIV) out_pix <= {acc[6:0], qbit};
        end
        DONE: if (out_ready) acc <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_convolver.sv
// Self-checking bench for kernel_convolver (SIZE=3): directed vector table, corner
// sequences and randomized windows compared with a plain weighted-average model.
module tb_kernel_convolver;

  localparam int SIZE  = 3;
  localparam int N     = SIZE * SIZE;
  localparam int SUM_W = 8 + $clog2(N);

  typedef logic [7:0] tap_t [N];
  typedef struct {
    string tag;
    tap_t  w;
    tap_t  p;
    int    expSum;
    int    expPix;
  } vec_t;

  logic                           clk = 1'b0;
  logic                           rst;
  logic [SIZE-1:0][SIZE-1:0][7:0] kernel;
  logic                           kernel_load;
  logic                           kernel_ready;
  logic [SUM_W-1:0]               ksum;
  logic                           err;
  logic [7:0]                     pix_in;
  logic                           pix_valid;
  logic                           pix_ready;
  logic [7:0]                     out_pix;
  logic                           out_valid;
  logic                           out_ready;

  int   checks = 0;
  int   errors = 0;
  bit   sawValid;
  vec_t vecs[3];

  kernel_convolver #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .kernel(kernel), .kernel_load(kernel_load),
    .kernel_ready(kernel_ready), .ksum(ksum), .err(err), .pix_in(pix_in),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .out_pix(out_pix),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic int modelSum(input tap_t w);
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(w[i]);
    return s;
  endfunction

  function automatic int modelPix(input tap_t w, input tap_t p);
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(w[i]) * int'(p[i]);
    return s / modelSum(w);
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Pulses kernel_load for one edge and counts cycles until kernel_ready or err.
  task automatic loadKernel(input tap_t w, input bit dropBeat, output int lat);
    @(negedge clk);
    for (int i = 0; i < N; i++) kernel[i / SIZE][i % SIZE] = w[i];
    kernel_load = 1'b1;
    if (dropBeat) begin
      pix_valid = 1'b1;
      pix_in    = 8'd200;
    end
    @(negedge clk);
    kernel_load = 1'b0;
    pix_valid   = 1'b0;
    lat = -1;
    sawValid = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
      if (kernel_ready || err) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic feedPixels(input tap_t p, input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          pix_valid = 1'b0;
          @(negedge clk);
        end
      end
      pix_in    = p[i];
      pix_valid = 1'b1;
      @(negedge clk);
    end
    pix_valid = 1'b0;
  endtask

  task automatic waitOut(output int lat);
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  // Holds out_ready low for 'hold' cycles, verifying the output is frozen, then accepts.
  task automatic acceptOut(input string tag, input int hold, input int expPix);
    for (int h = 0; h < hold; h++) begin
      checkOutput({tag, "_holdValid"}, out_valid, 1);
      checkOutput({tag, "_holdPix"}, out_pix, expPix);
      checkOutput({tag, "_holdPixReady"}, pix_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_validDrop"}, out_valid, 0);
    checkOutput({tag, "_pixReadyBack"}, pix_ready, 1);
  endtask

  task automatic applyStimulus(input vec_t v);
    int lat;
    loadKernel(v.w, 1'b0, lat);
    checkOutput({v.tag, "_readyLat"}, lat, N);
    checkOutput({v.tag, "_ksum"}, ksum, v.expSum);
    checkOutput({v.tag, "_err"}, err, 0);
    feedPixels(v.p, N, 1'b0);
    waitOut(lat);
    checkOutput({v.tag, "_outLat"}, lat, 16 + $clog2(N));
    checkOutput({v.tag, "_outPix"}, out_pix, v.expPix);
    acceptOut(v.tag, 0, v.expPix);
  endtask

  initial begin
    tap_t ones, zeros, flat, pix;
    int   lat, cnt, expPix, expSum, hold;

    rst = 1'b1; kernel = '0; kernel_load = 1'b0;
    pix_in = '0; pix_valid = 1'b0; out_ready = 1'b0;

    for (int i = 0; i < N; i++) begin
      ones[i] = 8'd1; zeros[i] = 8'd0;
    end

    vecs[0].tag = "ones100";
    vecs[1].tag = "center4";
    vecs[2].tag = "ones50";
    for (int i = 0; i < N; i++) begin
      vecs[0].w[i] = 8'd1; vecs[0].p[i] = 8'd100;
      vecs[1].w[i] = (i == 4) ? 8'd4 : 8'd1; vecs[1].p[i] = 8'(i);
      vecs[2].w[i] = 8'd1; vecs[2].p[i] = 8'd50;
    end
    vecs[0].expSum = 9;  vecs[0].expPix = 100;
    vecs[1].expSum = 12; vecs[1].expPix = 4;
    vecs[2].expSum = 9;  vecs[2].expPix = 50;

    @(negedge clk); @(negedge clk);
    checkOutput("resetOutputs", {kernel_ready, err, pix_ready, out_valid}, 0);
    checkOutput("resetKsum", ksum, 0);
    checkOutput("resetOutPix", out_pix, 0);
    rst = 1'b0;

    for (int k = 0; k < 3; k++) applyStimulus(vecs[k]);

    // Reset asserted after three beats of a window.
    for (int i = 0; i < N; i++) flat[i] = 8'd77;
    loadKernel(ones, 1'b0, lat);
    feedPixels(flat, 3, 1'b0);
    pix_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    checkOutput("midRstOutputs", {kernel_ready, err, pix_ready, out_valid}, 0);
    @(negedge clk);
    rst = 1'b0;
    pix_valid = 1'b0;
    sawValid = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      pix_valid = 1'b1;
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
      if (pix_ready || kernel_ready) cnt++;
    end
    pix_valid = 1'b0;
    checkOutput("postRstNoValid", sawValid, 0);
    checkOutput("postRstIdle", cnt, 0);
    applyStimulus(vecs[0]);

    // All-zero kernel raises err and blocks pixels; a good kernel clears it.
    loadKernel(zeros, 1'b0, lat);
    checkOutput("zeroErrLat", lat, N);
    checkOutput("zeroErr", err, 1);
    checkOutput("zeroReady", kernel_ready, 0);
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (pix_ready) cnt++;
    end
    checkOutput("zeroPixReady", cnt, 0);
    @(negedge clk);
    kernel = '0; kernel[1][1] = 8'd4; kernel_load = 1'b1;
    @(negedge clk);
    kernel_load = 1'b0;
    checkOutput("errCleared", err, 0);
    for (int c = 0; c < N; c++) @(negedge clk);
    checkOutput("afterErrReady", kernel_ready, 1);
    checkOutput("afterErrKsum", ksum, 4);

    // Backpressure in DONE, then an immediate next window from a clean accumulator.
    feedPixels(vecs[1].p, N, 1'b0);
    waitOut(lat);
    checkOutput("bpOutPix", out_pix, 4);
    acceptOut("bp", 5, 4);
    feedPixels(flat, N, 1'b0);
    waitOut(lat);
    checkOutput("bpNextPix", out_pix, 77);
    acceptOut("bpNext", 0, 77);

    // kernel_load after four beats aborts the window and drops the coincident beat.
    loadKernel(ones, 1'b0, lat);
    feedPixels(flat, 4, 1'b0);
    loadKernel(ones, 1'b1, lat);
    checkOutput("abortReadyLat", lat, N);
    checkOutput("abortNoValid", sawValid, 0);
    feedPixels(vecs[2].p, N, 1'b0);
    waitOut(lat);
    checkOutput("abortOutLat", lat, 16 + $clog2(N));
    checkOutput("abortOutPix", out_pix, 50);
    acceptOut("abort", 0, 50);

    // Randomized kernels, windows, input gaps and output stalls.
    for (int t = 0; t < 14; t++) begin
      tap_t w;
      for (int i = 0; i < N; i++) begin
        w[i]   = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        pix[i] = 8'($urandom_range(0, 255));
      end
      if (t == 5) for (int i = 0; i < N; i++) w[i] = 8'd0;
      expSum = modelSum(w);
      loadKernel(w, 1'b0, lat);
      checkOutput("rndReadyLat", lat, N);
      if (expSum == 0) begin
        checkOutput("rndErr", err, 1);
        continue;
      end
      checkOutput("rndKsum", ksum, expSum);
      expPix = modelPix(w, pix);
      feedPixels(pix, N, 1'b1);
      waitOut(lat);
      checkOutput("rndOutSeen", lat > 0, 1);
      checkOutput("rndOutPix", out_pix, expPix);
      hold = $urandom_range(0, 3);
      acceptOut("rnd", hold, expPix);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
